// File: rtl/adc_pkt_pkg.sv
// ADC packetizer shared definitions.
// Header field offsets and packet geometry helpers.
package adc_pkt_pkg;

  localparam int cVerOfs  = 0;
  localparam int cSeqOfs  = 8;
  localparam int cDropOfs = 16;
  localparam int cChOfs   = 24;
  localparam int cHdrBits = 32;

  function automatic int packetBits(
    input int ch,
    input int dw,
    input int sp
  );
    return cHdrBits + sp * ch * dw;
  endfunction

  function automatic int frameOfs(
    input int s,
    input int ch,
    input int dw
  );
    return cHdrBits + s * ch * dw;
  endfunction

endpackage

// File: rtl/adc_pkt_buffer.sv
// One packet image: frame slots written by index,
// header loaded separately when the packet closes.
module adc_pkt_buffer
  import adc_pkt_pkg::*;
#(
  parameter int pChannels         = 8,
  parameter int pAdcDataWidth     = 16,
  parameter int pSamplesPerPacket = 15,
  localparam int cFrameW = pChannels * pAdcDataWidth,
  localparam int cPktW   = packetBits(pChannels,
                             pAdcDataWidth,
                             pSamplesPerPacket)
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iWrEn,
  input  logic [7:0]          iIdx,
  input  logic [cFrameW-1:0]  iFrame,
  input  logic                iHdrLd,
  input  logic [cHdrBits-1:0] iHdr,
  output logic [cPktW-1:0]    oData
);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oData <= '0;
    end else begin
      if (iWrEn) begin
        for (int s = 0; s < pSamplesPerPacket; s++) begin
          if (iIdx == 8'(s)) begin
            oData[frameOfs(s, pChannels, pAdcDataWidth)
                  +: cFrameW] <= iFrame;
          end
        end
      end
      if (iHdrLd) begin
        oData[cHdrBits-1:0] <= iHdr;
      end
    end
  end

endmodule

// File: rtl/adc_packetizer.sv
// Ping-pong ADC packet builder: fills one buffer
// while the other waits on the packet FIFO.
module adc_packetizer
  import adc_pkt_pkg::*;
#(
  parameter int pChannels         = 8,
  parameter int pAdcDataWidth     = 16,
  parameter int pSamplesPerPacket = 15,
  parameter int pPacketVersion    = 0,
  parameter int pPacketBitWidth   =
    packetBits(pChannels, pAdcDataWidth,
               pSamplesPerPacket)
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic                     iWrEn,
  input  logic [pChannels*pAdcDataWidth-1:0]
                                   iAdcSampleData,
  input  logic                     iPacketWrFull,
  input  logic                     iErrClr,
  output logic                     oPacketWr,
  output logic [pPacketBitWidth-1:0] oPacketData,
  output logic                     oErr,
  output logic [7:0]               oDropCount
);

  localparam logic [7:0] cLast =
    8'(pSamplesPerPacket - 1);

  logic [7:0] idx;
  logic [7:0] seq;
  logic [7:0] dropCnt;
  logic       wrPtr;
  logic       rdPtr;
  logic [1:0] readyCnt;

  logic accept;
  logic drop;
  logic complete;
  logic emit;
  logic [1:0] bufWr;
  logic [1:0] bufHdr;
  logic [cHdrBits-1:0] hdr;
  logic [pPacketBitWidth-1:0] bufData [2];

  assign accept   = iWrEn && (readyCnt != 2'd2);
  assign drop     = iWrEn && (readyCnt == 2'd2);
  assign complete = accept && (idx == cLast);
  // Skip the cycle right after a write so the
  // FIFO sees at most one strobe every two cycles.
  assign emit     = (readyCnt != 2'd0) &&
                    !iPacketWrFull && !oPacketWr;

  assign bufWr  = accept ?
    (wrPtr ? 2'b10 : 2'b01) : 2'b00;
  assign bufHdr = complete ?
    (wrPtr ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    hdr = '0;
    hdr[cVerOfs  +: 8] = 8'(pPacketVersion);
    hdr[cSeqOfs  +: 8] = seq;
    hdr[cDropOfs +: 8] = dropCnt;
    hdr[cChOfs   +: 8] = 8'(pChannels);
  end

  for (genvar b = 0; b < 2; b++) begin : gBuf
    adc_pkt_buffer #(
      .pChannels        (pChannels),
      .pAdcDataWidth    (pAdcDataWidth),
      .pSamplesPerPacket(pSamplesPerPacket)
    ) uBuf (
      .iClk  (iClk),
      .iRstN (iRstN),
      .iWrEn (bufWr[b]),
      .iIdx  (idx),
      .iFrame(iAdcSampleData),
      .iHdrLd(bufHdr[b]),
      .iHdr  (hdr),
      .oData (bufData[b])
    );
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      idx      <= '0;
      seq      <= '0;
      dropCnt  <= '0;
      wrPtr    <= 1'b0;
      rdPtr    <= 1'b0;
      readyCnt <= '0;
    end else begin
      if (complete) begin
        idx   <= '0;
        seq   <= seq + 8'd1;
        wrPtr <= ~wrPtr;
      end else if (accept) begin
        idx <= idx + 8'd1;
      end
      if (complete) begin
        dropCnt <= '0;
      end else if (drop && dropCnt != 8'hFF) begin
        dropCnt <= dropCnt + 8'd1;
      end
      if (emit) begin
        rdPtr <= ~rdPtr;
      end
      unique case (1'b1)
        complete && !emit:
          readyCnt <= readyCnt + 2'd1;
        emit && !complete:
          readyCnt <= readyCnt - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oPacketWr   <= 1'b0;
      oPacketData <= '0;
      oErr        <= 1'b0;
    end else begin
      oPacketWr <= emit;
      if (emit) begin
        oPacketData <= bufData[rdPtr];
      end
      // A drop in the clearing cycle keeps the flag.
      if (drop) begin
        oErr <= 1'b1;
      end else if (iErrClr) begin
        oErr <= 1'b0;
      end
    end
  end

  assign oDropCount = dropCnt;

endmodule

// File: tb/tb_adc_packetizer.sv
// Directed bench for adc_packetizer with a
// queue-based packet model checked every cycle.
module tb_adc_packetizer;

  localparam int C  = 8;
  localparam int DW = 16;
  localparam int S  = 15;
  localparam int W  = 32 + S * C * DW;

  typedef logic [W-1:0] pkt_t;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic          wrEn = 1'b0;
  logic [C*DW-1:0] data = '0;
  logic          full = 1'b0;
  logic          errClr = 1'b0;
  logic          pWr;
  pkt_t          pData;
  logic          err;
  logic [7:0]    dropCnt;

  logic          wr2 = 1'b0;
  logic [95:0]   data2 = '0;
  logic          pWr2;
  logic [223:0]  pData2;
  logic          err2;
  logic [7:0]    drop2;

  int tests = 0;
  int fails = 0;
  int pktCnt = 0;

  always #5 clk = ~clk;

  adc_packetizer dut (
    .iClk          (clk),
    .iRstN         (rstN),
    .iWrEn         (wrEn),
    .iAdcSampleData(data),
    .iPacketWrFull (full),
    .iErrClr       (errClr),
    .oPacketWr     (pWr),
    .oPacketData   (pData),
    .oErr          (err),
    .oDropCount    (dropCnt)
  );

  adc_packetizer #(
    .pChannels        (4),
    .pAdcDataWidth    (24),
    .pSamplesPerPacket(2)
  ) dut2 (
    .iClk          (clk),
    .iRstN         (rstN),
    .iWrEn         (wr2),
    .iAdcSampleData(data2),
    .iPacketWrFull (1'b0),
    .iErrClr       (1'b0),
    .oPacketWr     (pWr2),
    .oPacketData   (pData2),
    .oErr          (err2),
    .oDropCount    (drop2)
  );

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h",
               nm, act, exp);
    end
  endtask

  // Behavioural model: packets as whole vectors
  // in a two-deep ready queue.
  pkt_t       rdyQ [$];
  pkt_t       cur = '0;
  int         mIdx = 0;
  logic [7:0] mSeq = '0;
  logic [7:0] mDrop = '0;
  logic       mErr = 1'b0;
  logic       expWr = 1'b0;
  pkt_t       expData = '0;
  int         mN;
  bit         mEm;
  pkt_t       mFront;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rdyQ.delete();
      cur = '0;
      mIdx = 0;
      mSeq = '0;
      mDrop = '0;
      mErr = 1'b0;
      expWr = 1'b0;
      expData = '0;
    end else begin
      mN = rdyQ.size();
      mEm = (mN > 0) && !full && !expWr;
      mFront = '0;
      if (mEm) mFront = rdyQ.pop_front();
      if (wrEn && mN < 2) begin
        for (int c = 0; c < C; c++)
          cur[32 + (mIdx*C + c)*DW +: DW] =
            data[c*DW +: DW];
        if (mIdx == S - 1) begin
          cur[31:0] = {8'(C), mDrop, mSeq, 8'h00};
          rdyQ.push_back(cur);
          mIdx = 0;
          mSeq = mSeq + 8'd1;
          mDrop = '0;
        end else begin
          mIdx++;
        end
      end else if (wrEn) begin
        if (mDrop != 8'hFF) mDrop = mDrop + 8'd1;
      end
      if (wrEn && mN == 2) mErr = 1'b1;
      else if (errClr) mErr = 1'b0;
      expWr = mEm;
      if (mEm) expData = mFront;
    end
  end

  always @(negedge clk) begin
    chk("m_wr", pWr, expWr);
    chk("m_err", err, mErr);
    chk("m_drop", dropCnt, mDrop);
    tests++;
    if (pData !== expData) begin
      fails++;
      $display("FAIL m_data act=%h exp=%h",
               pData[63:0], expData[63:0]);
    end
    if (pWr) pktCnt++;
  end

  task automatic sendFrame(input int v);
    for (int c = 0; c < C; c++)
      data[c*DW +: DW] = 16'(v + c);
    wrEn = 1'b1;
    @(posedge clk);
    #1;
    wrEn = 1'b0;
  endtask

  task automatic sendFrames(
    input int p,
    input int s0,
    input int n
  );
    for (int s = s0; s < s0 + n; s++)
      sendFrame(p*256 + s*8);
  endtask

  task automatic waitPkt(
    output int cyc,
    output pkt_t d
  );
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!pWr && cyc < 40);
    if (!pWr) chk("pkt_timeout", pWr, 1);
    d = pData;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    int   cyc;
    pkt_t d;
    int   pk0;

    #1 rstN = 1'b0;
    #1;
    chk("rst_wr", pWr, 0);
    chk("rst_data", pData[63:0], 0);
    chk("rst_err", err, 0);
    chk("rst_drop", dropCnt, 0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;

    sendFrames(0, 0, 15);
    chk("p1_pre", pWr, 0);
    waitPkt(cyc, d);
    chk("p1_lat", cyc, 1);
    chk("p1_hdr", d[31:0], 32'h0800_0000);
    chk("p1_f0c0", d[32 +: 16], 0);
    chk("p1_f14c7", d[1936 +: 16], 119);
    chk("p1_err", err, 0);
    @(posedge clk);
    #1;
    chk("p1_1cyc", pWr, 0);

    sendFrames(1, 0, 15);
    waitPkt(cyc, d);
    chk("p2_seq", d[15:8], 1);
    for (int p = 2; p < 257; p++) begin
      sendFrames(p, 0, 15);
      waitPkt(cyc, d);
      if (p == 255) chk("p256_seq", d[15:8], 255);
      if (p == 256) chk("p257_seq", d[15:8], 0);
    end

    doReset();
    full = 1'b1;
    sendFrames(0, 0, 15);
    sendFrames(1, 0, 15);
    pk0 = pktCnt;
    sendFrame(31 * 8);
    chk("f_err", err, 1);
    chk("f_drop1", dropCnt, 1);
    sendFrames(1, 16, 4);
    chk("f_drop5", dropCnt, 5);
    errClr = 1'b1;
    sendFrame(0);
    errClr = 1'b0;
    chk("f_clrdrop_err", err, 1);
    chk("f_drop6", dropCnt, 6);
    errClr = 1'b1;
    @(posedge clk);
    #1 errClr = 1'b0;
    chk("f_clr", err, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("f_nowr", pktCnt, pk0);
    full = 1'b0;
    waitPkt(cyc, d);
    chk("f_a_lat", cyc, 1);
    chk("f_a_hdr", d[31:0], 32'h0800_0000);
    waitPkt(cyc, d);
    chk("f_b_gap", cyc, 2);
    chk("f_b_hdr", d[31:0], 32'h0800_0100);
    sendFrames(2, 0, 15);
    waitPkt(cyc, d);
    chk("f_c_hdr", d[31:0], 32'h0806_0200);
    chk("f_c_drop", dropCnt, 0);

    full = 1'b1;
    sendFrames(3, 0, 15);
    sendFrames(4, 0, 14);
    full = 1'b0;
    sendFrame(4*256 + 14*8);
    chk("s_wr", pWr, 1);
    chk("s_seq", pData[15:8], 3);
    chk("s_cnt", dut.readyCnt, 1);
    chk("s_drop", dropCnt, 0);
    waitPkt(cyc, d);
    chk("s_gap", cyc, 2);
    chk("s_seq2", d[15:8], 4);

    sendFrames(5, 0, 7);
    #3 rstN = 1'b0;
    #1;
    chk("ar_wr", pWr, 0);
    chk("ar_data", {63'd0, |pData}, 0);
    chk("ar_err", err, 0);
    chk("ar_drop", dropCnt, 0);
    @(posedge clk);
    #1 rstN = 1'b1;
    sendFrames(6, 0, 15);
    waitPkt(cyc, d);
    chk("ar_lat", cyc, 1);
    chk("ar_hdr", d[31:0], 32'h0800_0000);
    chk("ar_f0", d[32 +: 16], 16'h0600);

    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 4; c++)
        data2[c*24 +: 24] = 24'hA00000 + 24'(s*16 + c);
      wr2 = 1'b1;
      @(posedge clk);
      #1 wr2 = 1'b0;
    end
    chk("g_pre", pWr2, 0);
    @(posedge clk);
    #1;
    chk("g_wr", pWr2, 1);
    chk("g_hdr", pData2[31:0], 32'h0400_0000);
    chk("g_f0c0", pData2[55:32], 24'hA00000);
    chk("g_f1c3", pData2[223:200], 24'hA00013);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=running exp=done");
    $fatal(1);
  end

endmodule
